irq_arbiter: RTL
================

// Module: irq_arbiter
//
// PURPOSE
//   Core-side consumer of the interrupt controller's int_pend/int_time outputs.
//   Registers the pending vector and masks it with mie/mideleg, mstatus and the current privilege.
//   Selects one interrupt by fixed RISC-V priority and presents it to commit as a trap request.
//   The request uses a valid/ack handshake. Also supplies a registered time value for rdtime and a WFI wake signal.
//
// PARAMETERS
//   NIRQ      64  width of pending/enable vectors (cause index = bit index)
//   COOLDOWN  2   cycles after ack before re-arbitration (lets trap-entry CSR writes land)
//
// PORTS
//   clk            in   1     clock
//   rst            in   1     synchronous, active-high reset
//   int_pend       in   NIRQ  level pending bits from interrupt controller
//   int_time       in   64    mtime from interrupt controller
//   csr_mie        in   NIRQ  interrupt enable CSR
//   csr_mideleg    in   NIRQ  delegation CSR (1 = handled in S)
//   csr_mstatus_mie in  1     global M enable
//   csr_mstatus_sie in  1     global S enable
//   priv           in   2     current privilege (0=U,1=S,3=M)
//   irq_valid      out  1     trap request to commit
//   irq_cause      out  6     cause index of request
//   irq_to_s       out  1     request targets S-mode (delegated)
//   irq_ack        in   1     commit takes trap this cycle
//   wfi_wake       out  1     any pend&mie bit set, ignoring global enables
//   time_q         out  64    int_time delayed one cycle
//
// BEHAVIOUR
//   Reset: all outputs 0; FSM=IDLE; registered pend/time = 0; cooldown counter = 0.
//   Stage 1 (edge): pend_q<=int_pend, time_q<=int_time. CSR/priv inputs are used unregistered.
//   Eligibility, computed from pend_q:
//     act = pend_q & csr_mie.
//     m_ok = act & ~mideleg, taken if priv!=3 || mstatus_mie.
//     s_ok = act & mideleg, taken if priv==0 || (priv==1 && mstatus_sie); never when priv==3.
//   Priority, highest first: 11 MEI, 3 MSI, 7 MTI, 9 SEI, 1 SSI, 5 STI, then 16..63 ascending.
//     Bits 0,2,4,6,8,10,12..15 are never selected.
//     Every M-eligible cause beats every S-eligible cause.
//   FSM:
//     IDLE->REQ when any eligible bit is set. Latch cause and to_s; irq_valid=1 from the next cycle.
//     REQ: cause and to_s are held stable. No preemption by newly arriving higher-priority causes.
//     REQ & irq_ack -> COOL. irq_valid drops the cycle after ack.
//     REQ & latched cause no longer eligible & !irq_ack -> IDLE (withdraw).
//     When ack and loss of eligibility fall in the same cycle, ack wins.
//     COOL counts COOLDOWN cycles, then goes to IDLE. irq_valid=0 throughout COOL.
//   Latency: int_pend rises before edge N -> irq_valid high after edge N+1 (2 edges).
//   wfi_wake = |act, combinational from pend_q; it is also active during REQ/COOL.
//   Reset mid-REQ: request dropped next edge, no ack expected.
//   NIRQ<64: upper cause indices are absent; irq_cause is zero-extended to 6 bits.
//
// STRUCTURE
//   irq_pkg holds:
//     cause localparams (IRQ_MEI=11 ... IRQ_STI=5)
//     priority order array
//     FSM enum {IDLE,REQ,COOL}
//     priv encodings
//   Sub-module irq_prio_enc: combinational NIRQ-bit mask -> {found, cause[5:0]} using package order.
//     Instantiated twice (M set, S set).
//
// TESTING
//   1. int_pend=1<<7, mie=1<<7, priv=3, MIE=1 -> irq_valid high 2 edges later, cause=7, to_s=0; ack -> valid low, none for 2 cycles.
//   2. pend bits 11,3,7,9 all set, all enabled, priv=0 -> cause=11; after ack+clear bit 11 -> cause=3.
//   3. mideleg=1<<9, pend=1<<9, priv=3 -> no request; priv=1, SIE=1 -> cause=9, to_s=1; SIE=0 -> none.
//   4. Request cause 7 pending, clear int_pend bit 7 before ack -> irq_valid drops; same-cycle ack instead -> COOL taken.
//   5. MIE=0, priv=3, pend&mie=1<<3 -> irq_valid=0, wfi_wake=1; int_time=0x1234 -> time_q=0x1234 one edge later.
//   6. Assert rst during REQ -> all outputs 0 next edge; pend still set after rst release -> new request after 2 edges.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt arbiter.
//   - RISC-V interrupt cause indices for the six architected causes
//   - fixed priority order of those causes (highest first)
//   - arbiter FSM state encoding
//   - privilege level encodings
package irq_pkg;

   localparam logic [5:0] IRQ_SSI = 6'd1;
   localparam logic [5:0] IRQ_MSI = 6'd3;
   localparam logic [5:0] IRQ_STI = 6'd5;
   localparam logic [5:0] IRQ_MTI = 6'd7;
   localparam logic [5:0] IRQ_SEI = 6'd9;
   localparam logic [5:0] IRQ_MEI = 6'd11;

   // Architected causes, highest priority first.
   localparam int NUM_FIXED = 6;
   localparam logic [5:0] PRIO_ORDER [NUM_FIXED] =
      '{IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI};

   // Platform causes start here and rank below the architected ones,
   // lower index first.
   localparam int FIRST_PLAIN = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      COOL = 2'd2
   } arb_state_e;

   localparam logic [1:0] PRIV_U = 2'd0;
   localparam logic [1:0] PRIV_S = 2'd1;
   localparam logic [1:0] PRIV_M = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational priority encoder over an eligible-interrupt mask.
//   mask_i   in  NIRQ  eligible causes (bit index = cause index)
//   found_o  out 1     any selectable cause present
//   cause_o  out 6     winning cause index (0 when found_o=0)
// Order: 11,3,7,9,1,5, then 16..63 ascending. Bits 0,2,4,6,8,10,12..15 are
// never selected even when set.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int NIRQ = 64
) (
   input  logic [NIRQ-1:0] mask_i,
   output logic            found_o,
   output logic [5:0]      cause_o
);

   logic [63:0] mask64;

   // Later assignments override earlier ones, so each loop walks from the
   // lowest priority to the highest and the final hit is the winner.
   always_comb begin
      mask64  = 64'(mask_i);
      found_o = 1'b0;
      cause_o = '0;
      for (int i = 63; i >= FIRST_PLAIN; i--) begin
         if (mask64[i]) begin
            found_o = 1'b1;
            cause_o = 6'(i);
         end
      end
      for (int k = NUM_FIXED - 1; k >= 0; k--) begin
         if (mask64[PRIO_ORDER[k]]) begin
            found_o = 1'b1;
            cause_o = PRIO_ORDER[k];
         end
      end
   end

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: registers the interrupt controller's pending vector, masks it
// with enable/delegation/global-enable/privilege, picks one cause by fixed
// priority and offers it to commit as a trap request.
//   clk, rst                 clock, synchronous active-high reset
//   int_pend, int_time       pending vector and mtime from the controller
//   csr_mie, csr_mideleg     enable and delegation CSRs (used unregistered)
//   csr_mstatus_mie/_sie     global M / S enables
//   priv                     current privilege (0=U, 1=S, 3=M)
//   irq_valid/_cause/_to_s   registered trap request
//   irq_ack                  commit takes the trap this cycle
//   wfi_wake                 |(pend_q & csr_mie), ignores global enables
//   time_q                   int_time delayed one cycle
//   fsm_state                arbiter state (IDLE/REQ/COOL) for observation
// Handshake: irq_valid stays high with cause/to_s frozen until commit raises
// irq_ack in a cycle where irq_valid is high; the request is consumed at that
// edge. Without an ack, the request is withdrawn if its latched cause stops
// being eligible. An ack always wins over a simultaneous loss of eligibility.
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int NIRQ     = 64,
   parameter int COOLDOWN = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NIRQ-1:0] int_pend,
   input  logic [63:0]     int_time,
   input  logic [NIRQ-1:0] csr_mie,
   input  logic [NIRQ-1:0] csr_mideleg,
   input  logic            csr_mstatus_mie,
   input  logic            csr_mstatus_sie,
   input  logic [1:0]      priv,
   output logic            irq_valid,
   output logic [5:0]      irq_cause,
   output logic            irq_to_s,
   input  logic            irq_ack,
   output logic            wfi_wake,
   output logic [63:0]     time_q,
   output logic [1:0]      fsm_state
);

   localparam int CW = $clog2(COOLDOWN + 2);

   logic [NIRQ-1:0] pend_q;
   arb_state_e      state_q;
   logic [CW-1:0]   cnt_q;
   logic            valid_q;
   logic [5:0]      cause_q;
   logic            to_s_q;

   logic [NIRQ-1:0] act;
   logic [NIRQ-1:0] m_elig;
   logic [NIRQ-1:0] s_elig;
   logic            m_en;
   logic            s_en;
   logic            m_found;
   logic            s_found;
   logic [5:0]      m_cause;
   logic [5:0]      s_cause;
   logic [63:0]     m_elig64;
   logic [63:0]     s_elig64;
   logic            latched_elig;

   assign act  = pend_q & csr_mie;
   // M-level interrupts are always taken below M; in M only with mstatus.MIE.
   assign m_en = (priv != PRIV_M) || csr_mstatus_mie;
   // Delegated interrupts are never taken in M.
   assign s_en = (priv == PRIV_U) || ((priv == PRIV_S) && csr_mstatus_sie);

   assign m_elig = m_en ? (act & ~csr_mideleg) : '0;
   assign s_elig = s_en ? (act & csr_mideleg) : '0;

   irq_prio_enc #(.NIRQ(NIRQ)) u_enc_m (
      .mask_i  (m_elig),
      .found_o (m_found),
      .cause_o (m_cause)
   );

   irq_prio_enc #(.NIRQ(NIRQ)) u_enc_s (
      .mask_i  (s_elig),
      .found_o (s_found),
      .cause_o (s_cause)
   );

   // Re-check the held cause against the current eligibility of its own class.
   assign m_elig64     = 64'(m_elig);
   assign s_elig64     = 64'(s_elig);
   assign latched_elig = to_s_q ? s_elig64[cause_q] : m_elig64[cause_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q  <= '0;
         time_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         cause_q <= '0;
         to_s_q  <= 1'b0;
      end else begin
         pend_q <= int_pend;
         time_q <= int_time;
         case (state_q)
            IDLE: begin
               if (m_found || s_found) begin
                  state_q <= REQ;
                  valid_q <= 1'b1;
                  // Any M-eligible cause outranks every S-eligible cause.
                  cause_q <= m_found ? m_cause : s_cause;
                  to_s_q  <= ~m_found;
               end
            end
            REQ: begin
               if (irq_ack) begin
                  state_q <= COOL;
                  valid_q <= 1'b0;
                  cnt_q   <= CW'(COOLDOWN);
               end else if (!latched_elig) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            COOL: begin
               // Holds off arbitration while trap-entry CSR updates land.
               if (cnt_q <= CW'(1)) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign irq_valid = valid_q;
   assign irq_cause = cause_q;
   assign irq_to_s  = to_s_q;
   assign wfi_wake  = |act;
   assign fsm_state = state_q;

endmodule
